// File: rtl/game_round_controller.sv
// Round controller: IDLE -> (COUNTDOWN) -> RUN <-> PAUSE -> DONE, with a live-compared tick limit.
// Optional pre-round countdown is built only when GAME_ROUND_COUNTDOWN_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a START edge; counter_out keeps the last round
// COUNTDOWN | 30-tick lead-in, countdown_out shows 3/2/1 (macro builds only)
// RUN       | counter_out advances one per tick until LIMIT is reached
// PAUSE     | counter and prescaler frozen; PAUSE resumes, START abandons
// DONE      | limit reached, counter frozen until the next START edge
module game_round_controller #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic       CLOCK10M,
  input  logic       KEY0,
  input  logic       START,
  input  logic       PAUSE,
  input  logic [3:0] SWITCH,
  input  logic [9:0] LIMIT,
  output logic [9:0] counter_out,
  output logic [2:0] state_out,
  output logic       time_up,
  output logic [1:0] countdown_out
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RUN       = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] presc_q;
  logic [9:0]  counter_q;
  logic        time_up_q;
  logic        start_prev_q;
  logic        pause_prev_q;

  logic [31:0] div;
  logic        en;
  logic        counting;
  logic        tick;
  logic        start_edge;
  logic        pause_edge;
  logic [10:0] counter_d;
  logic        limit_hit;
  logic        unused_sw;

  assign unused_sw  = SWITCH[3];
  assign en         = SWITCH[0];
  assign div        = TICK_DIV >> SWITCH[2:1];
  assign counting   = (state_q == ST_RUN) || (state_q == ST_COUNTDOWN);
  // The +1 form keeps a zero divider from underflowing; it simply ticks every cycle.
  assign tick       = en && counting && ((presc_q + 32'd1) >= div);
  assign start_edge = en && START && !start_prev_q;
  assign pause_edge = en && PAUSE && !pause_prev_q;
  assign counter_d  = {1'b0, counter_q} + 11'd1;
  assign limit_hit  = (LIMIT != 10'd0) && (counter_d >= {1'b0, LIMIT});

`ifdef GAME_ROUND_COUNTDOWN_EN
  logic [1:0] countdown_q;
  logic [3:0] sub_q;
`endif

  always_ff @(posedge CLOCK10M) begin
    if (KEY0) begin
      state_q      <= ST_IDLE;
      presc_q      <= 32'd0;
      counter_q    <= 10'd0;
      time_up_q    <= 1'b0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
`ifdef GAME_ROUND_COUNTDOWN_EN
      countdown_q  <= 2'd0;
      sub_q        <= 4'd0;
`endif
    end else begin
      // History tracks even while disabled so a held button never fires on re-enable.
      start_prev_q <= START;
      pause_prev_q <= PAUSE;
      time_up_q    <= 1'b0;
      if (en) begin
        case (state_q)
          ST_IDLE: begin
            if (start_edge) begin
              counter_q <= 10'd0;
              presc_q   <= 32'd0;
`ifdef GAME_ROUND_COUNTDOWN_EN
              state_q     <= ST_COUNTDOWN;
              countdown_q <= 2'd3;
              sub_q       <= 4'd0;
`else
              state_q   <= ST_RUN;
`endif
            end
          end
`ifdef GAME_ROUND_COUNTDOWN_EN
          ST_COUNTDOWN: begin
            if (start_edge) begin
              state_q     <= ST_IDLE;
              countdown_q <= 2'd0;
            end else begin
              presc_q <= tick ? 32'd0 : presc_q + 32'd1;
              if (tick) begin
                if (sub_q == 4'd9) begin
                  sub_q <= 4'd0;
                  if (countdown_q == 2'd1) begin
                    state_q     <= ST_RUN;
                    countdown_q <= 2'd0;
                  end else begin
                    countdown_q <= countdown_q - 2'd1;
                  end
                end else begin
                  sub_q <= sub_q + 4'd1;
                end
              end
            end
          end
`endif
          ST_RUN: begin
            presc_q <= tick ? 32'd0 : presc_q + 32'd1;
            if (tick) begin
              counter_q <= counter_d[9:0];
              if (limit_hit) begin
                state_q   <= ST_DONE;
                time_up_q <= 1'b1;
              end else if (pause_edge) begin
                state_q <= ST_PAUSE;
              end
            end else if (pause_edge) begin
              state_q <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (start_edge) begin
              state_q <= ST_IDLE;
            end else if (pause_edge) begin
              state_q <= ST_RUN;
            end
          end
          ST_DONE: begin
            if (start_edge) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign state_out   = state_q;
  assign counter_out = counter_q;
  assign time_up     = time_up_q;
`ifdef GAME_ROUND_COUNTDOWN_EN
  assign countdown_out = countdown_q;
`else
  assign countdown_out = 2'd0;
`endif

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller at TICK_DIV=8; covers limit, wrap, pause, reset,
// enable gating and (when GAME_ROUND_COUNTDOWN_EN is defined) the countdown lead-in.
module tb_game_round_controller;

  logic       clk;
  logic       KEY0;
  logic       START;
  logic       PAUSE;
  logic [3:0] SWITCH;
  logic [9:0] LIMIT;
  logic [9:0] counter_out;
  logic [2:0] state_out;
  logic       time_up;
  logic [1:0] countdown_out;

  int checks = 0;
  int errors = 0;

  game_round_controller #(.TICK_DIV(8)) dut (
    .CLOCK10M      (clk),
    .KEY0          (KEY0),
    .START         (START),
    .PAUSE         (PAUSE),
    .SWITCH        (SWITCH),
    .LIMIT         (LIMIT),
    .counter_out   (counter_out),
    .state_out     (state_out),
    .time_up       (time_up),
    .countdown_out (countdown_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    START = 1'b1;
    step(1);
    START = 1'b0;
  endtask

  task automatic press_pause();
    PAUSE = 1'b1;
    step(1);
    PAUSE = 1'b0;
  endtask

  // Leaves the DUT in RUN with the prescaler at 0; div is the current tick period.
  task automatic start_round(input int div);
    press_start();
`ifdef GAME_ROUND_COUNTDOWN_EN
    step(30 * div);
`endif
  endtask

  initial begin
    KEY0 = 1'b1; START = 1'b0; PAUSE = 1'b0; SWITCH = 4'b0001; LIMIT = 10'd0;
    step(2);
    KEY0 = 1'b0;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_counter", 32'(counter_out), 0);
    chk("rst_time_up", 32'(time_up), 0);
    chk("rst_countdown", 32'(countdown_out), 0);

`ifdef GAME_ROUND_COUNTDOWN_EN
    press_start();
    chk("cd_state", 32'(state_out), 1);
    chk("cd_3", 32'(countdown_out), 3);
    chk("cd_counter", 32'(counter_out), 0);
    step(79);
    chk("cd_3_end", 32'(countdown_out), 3);
    step(1);
    chk("cd_2", 32'(countdown_out), 2);
    step(80);
    chk("cd_1", 32'(countdown_out), 1);
    step(79);
    chk("cd_last", 32'(state_out), 1);
    step(1);
    chk("cd_to_run", 32'(state_out), 2);
    chk("cd_zero_run", 32'(countdown_out), 0);
    KEY0 = 1'b1; step(1); KEY0 = 1'b0;
    step(1);
    press_start();
    step(5);
    press_pause();
    chk("cd_pause_ignored", 32'(state_out), 1);
    step(1);
    press_start();
    chk("cd_abort", 32'(state_out), 0);
    chk("cd_abort_zero", 32'(countdown_out), 0);
    step(1);
`endif

    // Limit of 5 ticks
    LIMIT = 10'd5;
    start_round(8);
    chk("run_entry", 32'(state_out), 2);
    step(7);
    chk("pre_tick1", 32'(counter_out), 0);
    step(1);
    chk("tick1", 32'(counter_out), 1);
    for (int i = 2; i <= 4; i++) begin
      step(8);
      chk("tick_n", 32'(counter_out), 32'(i));
    end
    step(8);
    chk("lim_counter", 32'(counter_out), 5);
    chk("lim_done", 32'(state_out), 4);
    chk("lim_pulse", 32'(time_up), 1);
    step(1);
    chk("lim_pulse_end", 32'(time_up), 0);
    step(16);
    chk("done_hold", 32'(counter_out), 5);
    chk("done_state", 32'(state_out), 4);
    chk("done_no_pulse", 32'(time_up), 0);
    press_start();
    chk("done_to_idle", 32'(state_out), 0);
    chk("idle_keeps", 32'(counter_out), 5);
    step(1);

    // Pause and resume
    LIMIT = 10'd0;
    start_round(8);
    chk("p_clear", 32'(counter_out), 0);
    step(24);
    chk("p_three", 32'(counter_out), 3);
    step(5);
    press_pause();
    chk("p_enter", 32'(state_out), 3);
    step(20);
    chk("p_hold_cnt", 32'(counter_out), 3);
    chk("p_hold_state", 32'(state_out), 3);
    press_pause();
    chk("p_resume", 32'(state_out), 2);
    step(1);
    chk("p_resume_wait", 32'(counter_out), 3);
    step(1);
    chk("p_resume_tick", 32'(counter_out), 4);
    step(1);
    press_pause();
    chk("p_again", 32'(state_out), 3);
    step(1);
    START = 1'b1; PAUSE = 1'b1;
    step(1);
    START = 1'b0; PAUSE = 1'b0;
    chk("p_start_prio", 32'(state_out), 0);
    chk("p_abort_keeps", 32'(counter_out), 4);
    step(1);

    // START ignored in RUN, then reset mid-round at 7
    start_round(8);
    step(1);
    press_start();
    chk("run_ign_start", 32'(state_out), 2);
    step(54);
    chk("seven", 32'(counter_out), 7);
    KEY0 = 1'b1; step(1); KEY0 = 1'b0;
    chk("mid_rst_state", 32'(state_out), 0);
    chk("mid_rst_cnt", 32'(counter_out), 0);
    chk("mid_rst_tu", 32'(time_up), 0);
    step(1);

    // Global enable gating
    start_round(8);
    step(20);
    chk("en_pre", 32'(counter_out), 2);
    SWITCH[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      START = i[2];
      PAUSE = i[3];
      step(1);
      chk("dis_cnt", 32'(counter_out), 2);
      chk("dis_state", 32'(state_out), 2);
    end
    START = 1'b0; PAUSE = 1'b0;
    step(1);
    SWITCH[0] = 1'b1;
    step(3);
    chk("reen_wait", 32'(counter_out), 2);
    step(1);
    chk("reen_tick", 32'(counter_out), 3);
    SWITCH[0] = 1'b0;
    PAUSE = 1'b1;
    step(2);
    SWITCH[0] = 1'b1;
    step(2);
    chk("held_no_edge", 32'(state_out), 2);
    PAUSE = 1'b0;
    KEY0 = 1'b1; PAUSE = 1'b1;
    step(1);
    KEY0 = 1'b0; PAUSE = 1'b0;
    chk("rst_prio", 32'(state_out), 0);
    step(1);

    // Fast ticks, wrap, no DONE with LIMIT=0
    SWITCH = 4'b0101;
    start_round(2);
    step(1);
    chk("fast_half", 32'(counter_out), 0);
    step(1);
    chk("fast_one", 32'(counter_out), 1);
    step(2 * 1022);
    chk("wrap_top", 32'(counter_out), 1023);
    step(2);
    chk("wrap_zero", 32'(counter_out), 0);
    chk("wrap_state", 32'(state_out), 2);
    step(12);
    chk("wrap_six", 32'(counter_out), 6);
    chk("no_done", 32'(state_out), 2);

    // LIMIT lowered below the count ends the round on the next tick
    LIMIT = 10'd3;
    step(2);
    chk("live_cnt", 32'(counter_out), 7);
    chk("live_done", 32'(state_out), 4);
    chk("live_pulse", 32'(time_up), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
